// File: rtl/ifu.sv
// Instruction fetch unit: walks a PC through a combinational instruction ROM,
// buffers {pc, inst} packets in a 2-entry FIFO for decode, and handles redirect/EBREAK halt.
module ifu #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_o,
    output logic        fetch_en_o,
    input  logic [31:0] inst_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_inst_o,
    output logic        halted_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_halted;
    logic        r_misalign;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_cnt;
    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_mem_pc   [2];
    logic [31:0] r_mem_inst [2];

    logic w_redirect;
    logic w_push;
    logic w_pop;
    logic w_is_ebreak;

    // Decode handshake: a packet transfers on any cycle where out_valid_o and
    // out_ready_i are both high; out_valid_o never depends on out_ready_i.
    assign w_redirect  = redirect_valid_i && (r_state != ST_BOOT);
    assign fetch_en_o  = (r_state == ST_RUN) && (r_count < 2'd2) && !redirect_valid_i;
    assign w_push      = fetch_en_o;
    assign out_valid_o = (r_count != 2'd0);
    assign w_pop       = out_valid_o && out_ready_i;
    assign w_is_ebreak = (inst_i == EBREAK_INST);

    assign pc_o        = r_pc;
    assign out_pc_o    = r_mem_pc[r_rd_ptr];
    assign out_inst_o  = r_mem_inst[r_rd_ptr];
    assign halted_o    = r_halted;
    assign misalign_o  = r_misalign;
    assign fetch_cnt_o = r_fetch_cnt;
    assign state_o     = r_state;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_BOOT;
            r_halted <= 1'b0;
        end else if (w_redirect) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
                ST_RUN: begin
                    if (w_push && w_is_ebreak) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_BOOT;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc        <= RESET_PC;
            r_count     <= 2'd0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_fetch_cnt <= 32'd0;
            r_misalign  <= 1'b0;
        end else if (w_redirect) begin
            // A pop in this cycle is still delivered; everything left is dropped.
            r_pc       <= {redirect_pc_i[31:2], 2'b00};
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_misalign <= (redirect_pc_i[1:0] != 2'b00);
        end else begin
            r_misalign <= 1'b0;
            if (w_push) begin
                r_pc        <= r_pc + 32'd4;
                r_wr_ptr    <= ~r_wr_ptr;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count says they are valid.
    always_ff @(posedge clk_i) begin
        if (w_push && !w_redirect) begin
            r_mem_pc[r_wr_ptr]   <= r_pc;
            r_mem_inst[r_wr_ptr] <= inst_i;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: a directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based behavioural model.
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_o;
  logic        fetch_en_o;
  logic [31:0] inst_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic        halted_o;
  logic        misalign_o;
  logic [31:0] fetch_cnt_o;
  logic [1:0]  state_o;

  ifu #(.RESET_PC(RESET_PC), .EBREAK_INST(EBREAK)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_o(pc_o), .fetch_en_o(fetch_en_o), .inst_i(inst_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .out_inst_o(out_inst_o), .halted_o(halted_o), .misalign_o(misalign_o),
    .fetch_cnt_o(fetch_cnt_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // instruction ROM: pc ^ 1, with an optional EBREAK planted at one address
  logic        ebreak_en;
  logic [31:0] ebreak_pc;

  function automatic logic [31:0] rom(input logic [31:0] pc);
    if (ebreak_en && pc == ebreak_pc) return EBREAK;
    return pc ^ 32'h1;
  endfunction

  assign inst_i = rom(pc_o);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: fetch buffer as a queue of {pc, inst}
  logic        m_boot, m_halt, m_mis;
  logic [31:0] m_pc, m_cnt;
  logic [63:0] m_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0;
    m_pc = RESET_PC; m_cnt = 32'd0;
    m_q.delete();
  endtask

  // Compare one cycle against the model, then advance both across the clock edge.
  task automatic cycle();
    logic        exp_fe, exp_v, do_push, do_pop;
    logic [63:0] head;
    #1;
    exp_v  = (m_q.size() != 0);
    exp_fe = !m_boot && !m_halt && (m_q.size() < 2) && !redirect_valid_i;
    chk("pc_o", pc_o, m_pc);
    chk("fetch_en", {31'd0, fetch_en_o}, {31'd0, exp_fe});
    chk("out_valid", {31'd0, out_valid_o}, {31'd0, exp_v});
    if (exp_v) begin
      head = m_q[0];
      chk("out_pc", out_pc_o, head[63:32]);
      chk("out_inst", out_inst_o, head[31:0]);
    end
    chk("halted", {31'd0, halted_o}, {31'd0, m_halt});
    chk("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
    chk("fetch_cnt", fetch_cnt_o, m_cnt);
    do_pop  = exp_v && out_ready_i;
    do_push = exp_fe;
    if (do_pop) got_q.push_back(out_pc_o);
    if (!m_boot && redirect_valid_i) begin
      m_q.delete();
      m_pc   = {redirect_pc_i[31:2], 2'b00};
      m_halt = 1'b0;
      m_mis  = (redirect_pc_i[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back({m_pc, rom(m_pc)});
        if (rom(m_pc) == EBREAK) m_halt = 1'b1;
        m_pc  = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
    end
    m_boot = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'd0; out_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_fetch_en", {31'd0, fetch_en_o}, 32'd0);
    chk("rst_pc", pc_o, RESET_PC);
    chk("rst_fetch_cnt", fetch_cnt_o, 32'd0);
    chk("rst_halted", {31'd0, halted_o}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    rst_i = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        fe;
    logic        v;
    logic [31:0] pc;
    logic [31:0] opc;
    logic        mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0004, 32'h8000_0000, 1'b0, 32'd1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0008, 32'h8000_0000, 1'b0, 32'd2};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0008, 32'h8000_0000, 1'b0, 32'd2};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0008, 32'h8000_0000, 1'b0, 32'd2};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0008, 32'h8000_0004, 1'b0, 32'd2};
    vecs[7]  = '{1'b0, 1'b1, 32'h8000_0103, 1'b0, 1'b1, 32'h8000_000C, 32'h8000_0004, 1'b0, 32'd3};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0100, 32'h0,         1'b1, 32'd3};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0104, 32'h8000_0100, 1'b0, 32'd4};
    vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0108, 32'h8000_0104, 1'b0, 32'd5};

    ebreak_en = 1'b0; ebreak_pc = 32'h8000_0008;

    // directed table: stall, drain, redirect to a misaligned target
    do_reset();
    for (int i = 0; i < 11; i++) begin
      out_ready_i = vecs[i].rdy; redirect_valid_i = vecs[i].redir; redirect_pc_i = vecs[i].rpc;
      #1;
      chk($sformatf("vec%0d_fetch_en", i), {31'd0, fetch_en_o}, {31'd0, vecs[i].fe});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid_o}, {31'd0, vecs[i].v});
      chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].pc);
      chk($sformatf("vec%0d_misalign", i), {31'd0, misalign_o}, {31'd0, vecs[i].mis});
      chk($sformatf("vec%0d_fetch_cnt", i), fetch_cnt_o, vecs[i].cnt);
      if (vecs[i].v) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc_o, vecs[i].opc);
        chk($sformatf("vec%0d_out_inst", i), out_inst_o, vecs[i].opc ^ 32'h1);
      end
      @(posedge clk_i);
      #1;
    end

    // EBREAK halts fetch; a redirect resumes it
    ebreak_en = 1'b1; ebreak_pc = 32'h8000_0008;
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("halt_halted", {31'd0, halted_o}, 32'd1);
    chk("halt_fetch_en", {31'd0, fetch_en_o}, 32'd0);
    chk("halt_fetch_cnt", fetch_cnt_o, 32'd3);
    chk("halt_drained", {31'd0, out_valid_o}, 32'd0);
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0000;
    cycle();
    redirect_valid_i = 1'b0;
    #1;
    chk("resume_halted", {31'd0, halted_o}, 32'd0);
    chk("resume_fetch_en", {31'd0, fetch_en_o}, 32'd1);
    for (int i = 0; i < 4; i++) cycle();

    // PC wrap across the top of the address space
    ebreak_en = 1'b0;
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    cycle();
    redirect_valid_i = 1'b0;
    got_q.delete();
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    for (int i = 0; i < 6; i++) cycle();
    chk("wrap_count", {31'd0, got_q.size() >= 3}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) chk($sformatf("wrap_pkt%0d", i), got_q[i], exp_q[i]);
    end

    // reset asserted with the buffer full
    do_reset();
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("full_valid", {31'd0, out_valid_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("midrst_pc", pc_o, RESET_PC);
    chk("midrst_fetch_cnt", fetch_cnt_o, 32'd0);
    chk("midrst_fetch_en", {31'd0, fetch_en_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    model_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // randomized traffic against the model
    ebreak_en = 1'b1; ebreak_pc = 32'h8000_0040;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      redirect_valid_i = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc_i = $urandom;
        1:       redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redirect_pc_i = 32'h8000_0000 | 32'($urandom_range(0, 127));
      endcase
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter: RESET_PC, default 32'h8000_0000, PC loaded on reset.
REQ-002 Parameter: EBREAK_INST, default 32'h0010_0073, encoding that halts fetch.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-005 pc_o  output  32  fetch address presented to the instruction ROM.
REQ-006 fetch_en_o  output  1  fetch strobe; ROM lookup is valid and consumed only when 1.
REQ-007 inst_i  input  32  instruction returned combinationally by ROM for pc_o in the same cycle.
REQ-008 redirect_valid_i  input  1  branch/jump redirect request from execute.
REQ-009 redirect_pc_i  input  32  redirect target.
REQ-010 out_valid_o  output  1  fetch packet available to decode.
REQ-011 out_ready_i  input  1  decode accepts packet.
REQ-012 out_pc_o  output  32  PC of the head packet.
REQ-013 out_inst_o  output  32  instruction of the head packet.
REQ-014 halted_o  output  1  fetch halted after EBREAK.
REQ-015 misalign_o  output  1  one-cycle pulse: redirect target not word-aligned.
REQ-016 fetch_cnt_o  output  32  count of instructions pushed into the buffer.

Function
REQ-017 FSM states BOOT, RUN, HALT; BOOT -> RUN unconditionally after one cycle.
REQ-018 fetch_en_o = (state == RUN) && (count < 2) && !redirect_valid_i; pc_o = pc_q always.
REQ-019 Buffer: 2-entry FIFO of {pc, inst}; out_valid_o = (count != 0); head entry drives out_pc_o/out_inst_o.
REQ-020 Push on fetch_en_o: enqueue {pc_q, inst_i}; pc_q <= pc_q + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-021 Pop on out_valid_o && out_ready_i; head advances next edge.
REQ-022 Push and pop in the same cycle: count unchanged, order preserved.
REQ-023 Full (count == 2): no push even if pop occurs that cycle; fetch resumes the cycle after count < 2.
REQ-024 Empty: out_valid_o = 0; out_pc_o/out_inst_o values are don't-care.
REQ-025 Redirect (any state except BOOT) has priority: next edge pc_q <= {redirect_pc_i[31:2], 2'b00}, FIFO count <= 0, state <= RUN, no push that cycle.
REQ-026 Pop coinciding with redirect counts as completed for decode; all remaining entries are discarded.
REQ-027 redirect_pc_i[1:0] != 0 at redirect: misalign_o = 1 on the following cycle only; alignment per REQ-025.
REQ-028 Pushed inst_i == EBREAK_INST: entry is enqueued normally; state -> HALT next edge; pc_q still advances by 4.
REQ-029 HALT: fetch_en_o = 0, halted_o = 1, FIFO drains normally; leaves only via redirect or reset.
REQ-030 fetch_cnt_o increments by 1 per push, wraps at 2^32, unaffected by redirect.
REQ-031 Redirect in BOOT is ignored.

Reset
REQ-032 rst_i low asynchronously forces: state BOOT, pc_q = RESET_PC, count 0, fetch_cnt_o 0, halted_o 0, misalign_o 0.
REQ-033 During and in the first cycle after reset: fetch_en_o = 0, out_valid_o = 0.
REQ-034 Reset asserted mid-operation discards all buffered packets with no out_valid_o glitch after release.

Verification
REQ-035 Release reset, ROM returns pc^32'h1, out_ready_i = 1 -> first push cycle 2; packets 8000_0000, 8000_0004, ... each emitted once in order.
REQ-036 out_ready_i = 0 for 5 cycles -> exactly 2 pushes, fetch_en_o = 0 after, fetch_cnt_o = 2; release ready -> 8000_0000, 8000_0004 delivered first, no loss/duplication.
REQ-037 Redirect to 8000_0103 while 2 entries buffered -> FIFO flushed, misalign_o pulses once, next packet pc = 8000_0100.
REQ-038 ROM returns 0010_0073 at 8000_0008 -> packet delivered, halted_o = 1, no further fetch_en_o; redirect to 8000_0000 -> RUN, fetch resumes.
REQ-039 Redirect to FFFF_FFF8 -> packets FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
REQ-040 Assert rst_i low mid-stream with count = 2 -> out_valid_o = 0 immediately, pc_o = 8000_0000, fetch_cnt_o = 0.
